// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the ID/EX pipeline register slice.
// Holds the control-bundle layout, ALU-op encodings, data-bundle field
// offsets and the hard-wired zero register index.
package cpu_pkg;

  // Control bundle {RegDs,Branch,MRead,MtoR,AOp[2:0],MWrite,ALUsrc,Urw}
  localparam int CTRL_W     = 10;
  localparam int C_REGDS    = 9;
  localparam int C_BRANCH   = 8;
  localparam int C_MREAD    = 7;
  localparam int C_MTOR     = 6;
  localparam int C_AOP_MSB  = 5;
  localparam int C_AOP_LSB  = 3;
  localparam int C_MWRITE   = 2;
  localparam int C_ALUSRC   = 1;
  localparam int C_URW      = 0;

  // ALU-op encodings carried in the AOp field
  localparam logic [2:0] AOP_BEQ  = 3'b001;
  localparam logic [2:0] AOP_R    = 3'b010;
  localparam logic [2:0] AOP_MEM  = 3'b011;  // LW / SW / ADDI
  localparam logic [2:0] AOP_SLTI = 3'b100;
  localparam logic [2:0] AOP_ANDI = 3'b101;
  localparam logic [2:0] AOP_ORI  = 3'b110;

  typedef struct packed {
    logic       regds;
    logic       branch;
    logic       mread;
    logic       mtor;
    logic [2:0] aop;
    logic       mwrite;
    logic       alusrc;
    logic       urw;
  } ctrl_t;

  // Data bundle {pc4,rd1,rd2,imm,rs,rt,rd}; register indices sit at the bottom
  localparam int REG_W   = 5;
  localparam int RD_LSB  = 0;
  localparam int RT_LSB  = 5;
  localparam int RS_LSB  = 10;
  localparam int IMM_LSB = 15;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Word-field offsets scale with the datapath width
  function automatic int rd2_lsb(input int dw);
    return IMM_LSB + dw;
  endfunction

  function automatic int rd1_lsb(input int dw);
    return IMM_LSB + 2 * dw;
  endfunction

  function automatic int pc4_lsb(input int dw);
    return IMM_LSB + 3 * dw;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard check between EX and ID.
// Ports: ex_valid_i/ex_mread_i/ex_rt_i describe the EX slot; id_valid_i,
// id_rs_i, id_rt_i describe the ID slot; flush_i squashes; stall_o result.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             flush_i,
  output logic             stall_o
);

  logic rt_nonzero;
  logic src_match;

  assign rt_nonzero = (ex_rt_i != REG_ZERO);
  // rt is compared for every opcode; a spurious stall for SW/BEQ/I-type
  // costs one cycle but never corrupts state.
  assign src_match  = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);

  assign stall_o = ex_valid_i & ex_mread_i & id_valid_i & ~flush_i &
                   rt_nonzero & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with bubble insertion and an
// optional load-use hazard detector (enabled by macro ID_EX_HAZARD_EN).
// Ports: clk, rst_n (async active-low); id_valid_i/ctrl_i/data_i from ID;
// flush_i squash; ex_valid_o/ctrl_o/data_o to EX; stall_o holds PC and
// IF/ID; stall_cnt_o counts inserted load-use bubbles (saturating).
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [4*DW+14:0]  data_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [4*DW+14:0]  data_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic             ex_valid_q, ex_valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [4*DW+14:0] data_q, data_d;
  logic             stall;

  // Flush outranks stall; either one loads a bubble and leaves the data
  // bundle untouched. ctrl_i is masked so an idle ID slot cannot leak X.
  always_comb begin
    ex_valid_d = id_valid_i;
    ctrl_d     = id_valid_i ? ctrl_t'(ctrl_i) : '0;
    data_d     = data_i;
    if (flush_i || stall) begin
      ex_valid_d = 1'b0;
      ctrl_d     = '0;
      data_d     = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= '0;
      data_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
    end
  end

`ifdef ID_EX_HAZARD_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  load_use_detect u_load_use_detect (
    .ex_valid_i (ex_valid_q),
    .ex_mread_i (ctrl_q.mread),
    .ex_rt_i    (data_q[RT_LSB +: REG_W]),
    .id_valid_i (id_valid_i),
    .id_rs_i    (data_i[RS_LSB +: REG_W]),
    .id_rt_i    (data_i[RT_LSB +: REG_W]),
    .flush_i    (flush_i),
    .stall_o    (stall)
  );

  // Saturate rather than wrap so a long run never reads back as small.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall       = 1'b0;
  assign stall_cnt_o = '0;
`endif

  assign ex_valid_o = ex_valid_q;
  assign ctrl_o     = ctrl_q;
  assign data_o     = data_q;
  assign stall_o    = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test of the ID/EX register with a
// behavioural reference model checked every cycle plus literal pins.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int DW    = 32;
  localparam int CNT_W = 2;
  localparam int DBW   = 4 * DW + 15;
`ifdef ID_EX_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              id_valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DBW-1:0]    data_i;
  logic              flush_i;
  logic              ex_valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DBW-1:0]    data_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid_i  (id_valid_i),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .flush_i     (flush_i),
    .ex_valid_o  (ex_valid_o),
    .ctrl_o      (ctrl_o),
    .data_o      (data_o),
    .stall_o     (stall_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [CTRL_W-1:0] mk_ctrl(input bit regds, input bit branch,
      input bit mread, input bit mtor, input logic [2:0] aop, input bit mwrite,
      input bit alusrc, input bit urw);
    return {regds, branch, mread, mtor, aop, mwrite, alusrc, urw};
  endfunction

  function automatic logic [DBW-1:0] pack(input logic [DW-1:0] pc4, input logic [DW-1:0] rd1,
      input logic [DW-1:0] rd2, input logic [DW-1:0] imm, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd);
    return {pc4, rd1, rd2, imm, rs, rt, rd};
  endfunction

  // ---------------- reference model ----------------
  bit              m_valid = 1'b0;
  logic [9:0]      m_ctrl  = '0;
  logic [DBW-1:0]  m_data  = '0;
  int              m_cnt   = 0;
  localparam int   CNT_MAX = (1 << CNT_W) - 1;

  // A load in EX whose destination (non-zero) feeds the ID instruction.
  function automatic bit m_stall();
    logic [4:0] ex_dst, id_a, id_b;
    bit is_load;
    ex_dst  = m_data[9:5];
    id_a    = data_i[14:10];
    id_b    = data_i[9:5];
    is_load = m_ctrl[7];
    if (!HZ) return 1'b0;
    return m_valid && is_load && id_valid_i && !flush_i && ex_dst != 0 &&
           (ex_dst == id_a || ex_dst == id_b);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit s;
    if (!rst_n) begin
      m_valid = 1'b0; m_ctrl = '0; m_data = '0; m_cnt = 0;
    end else begin
      s = m_stall();
      if (flush_i || s) begin
        m_valid = 1'b0;
        m_ctrl  = '0;
      end else begin
        m_valid = id_valid_i;
        m_ctrl  = id_valid_i ? ctrl_i : 10'd0;
        m_data  = data_i;
      end
      if (s && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_valid", 160'(ex_valid_o), 160'(m_valid));
      chk("cyc_ctrl",  160'(ctrl_o),     160'(m_ctrl));
      chk("cyc_data",  160'(data_o),     160'(m_data));
      chk("cyc_stall", 160'(stall_o),    160'(m_stall()));
      chk("cyc_cnt",   160'(stall_cnt_o), 160'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [DBW-1:0] d,
      input bit f);
    @(negedge clk);
    #1;
    id_valid_i = v; ctrl_i = c; data_i = d; flush_i = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [CTRL_W-1:0] C_R, C_LW;
  logic [DBW-1:0]    d_lw8, d_lw0, d_add8, d_addrt8, d_ind, d_add0, d_r5, d_idle;

  initial begin
    C_R      = mk_ctrl(1, 0, 0, 0, AOP_R,   0, 0, 1);
    C_LW     = mk_ctrl(0, 0, 1, 1, AOP_MEM, 0, 1, 1);
    d_r5     = pack(32'h4, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3);
    d_lw8    = pack(32'h10, 32'hA0, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0);
    d_lw0    = pack(32'h14, 32'hA0, 32'h0, 32'h8, 5'd1, 5'd0, 5'd0);
    d_add8   = pack(32'h18, 32'h1, 32'h2, 32'h0, 5'd8, 5'd9, 5'd10);
    d_addrt8 = pack(32'h1C, 32'h1, 32'h2, 32'h0, 5'd2, 5'd8, 5'd11);
    d_ind    = pack(32'h20, 32'h3, 32'h4, 32'h0, 5'd3, 5'd4, 5'd12);
    d_add0   = pack(32'h24, 32'h3, 32'h4, 32'h0, 5'd0, 5'd0, 5'd13);
    d_idle   = pack(32'hDEAD, 32'hBEEF, 32'h1, 32'h2, 5'd8, 5'd8, 5'd1);

    id_valid_i = 1'b0; ctrl_i = '0; data_i = '0; flush_i = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 160'(ex_valid_o), 160'(0));
    chk("rst_ctrl",  160'(ctrl_o),     160'(0));
    chk("rst_data",  160'(data_o),     160'(0));
    chk("rst_cnt",   160'(stall_cnt_o), 160'(0));
    #10 rst_n = 1'b1;
    cmp_en = 1'b1;

    // pipe test
    drive(1, C_R, d_r5, 0);
    tick();
    chk("pipe_valid", 160'(ex_valid_o), 160'(1));
    chk("pipe_aop",   160'(ctrl_o[5:3]), 160'(3'b010));
    chk("pipe_rd1",   160'(data_o[DBW-DW-1 -: DW]), 160'(32'h5));

    // load-use via rs
    drive(1, C_LW, d_lw8, 0);
    drive(1, C_R, d_add8, 0);
    chk("lu_stall", 160'(stall_o), 160'(HZ));
    tick();
    chk("lu_bub_valid", 160'(ex_valid_o), 160'(!HZ));
    chk("lu_bub_ctrl",  160'(ctrl_o), HZ ? 160'(0) : 160'(C_R));
    chk("lu_cnt",       160'(stall_cnt_o), 160'(HZ));
    chk("lu_stall_off", 160'(stall_o), 160'(0));

    // load to $0 and independent consumer never stall
    drive(1, C_LW, d_lw0, 0);
    drive(1, C_R, d_add0, 0);
    chk("zero_stall", 160'(stall_o), 160'(0));
    tick();
    chk("zero_valid", 160'(ex_valid_o), 160'(1));
    drive(1, C_LW, d_lw8, 0);
    drive(1, C_R, d_ind, 0);
    chk("ind_stall", 160'(stall_o), 160'(0));
    tick();
    chk("ind_data", 160'(data_o), 160'(d_ind));

    // flush beats stall
    drive(1, C_LW, d_lw8, 0);
    drive(1, C_R, d_add8, 1);
    chk("fl_stall", 160'(stall_o), 160'(0));
    tick();
    chk("fl_valid", 160'(ex_valid_o), 160'(0));
    chk("fl_ctrl",  160'(ctrl_o), 160'(0));
    chk("fl_data",  160'(data_o), 160'(d_lw8));
    chk("fl_cnt",   160'(stall_cnt_o), 160'(HZ));

    // idle ID slot masks garbage control
    drive(0, 10'h3FF, d_idle, 0);
    tick();
    chk("idle_valid", 160'(ex_valid_o), 160'(0));
    chk("idle_ctrl",  160'(ctrl_o), 160'(0));
    chk("idle_data",  160'(data_o), 160'(d_idle));

    // saturation: five more load-use pairs, alternating rs / rt match
    for (int i = 0; i < 5; i++) begin
      drive(1, C_LW, d_lw8, 0);
      drive(1, C_R, (i % 2 == 0) ? d_add8 : d_addrt8, 0);
      tick();
    end
    chk("sat_cnt", 160'(stall_cnt_o), HZ ? 160'(3) : 160'(0));

    // reset mid-stall
    drive(1, C_LW, d_lw8, 0);
    drive(1, C_R, d_add8, 0);
    #1;
    chk("rs_stall_pre", 160'(stall_o), 160'(HZ));
    rst_n = 1'b0;
    #1;
    chk("rs_valid", 160'(ex_valid_o), 160'(0));
    chk("rs_ctrl",  160'(ctrl_o), 160'(0));
    chk("rs_data",  160'(data_o), 160'(0));
    chk("rs_stall", 160'(stall_o), 160'(0));
    chk("rs_cnt",   160'(stall_cnt_o), 160'(0));
    rst_n = 1'b1;
    tick();
    chk("rs_load_valid", 160'(ex_valid_o), 160'(1));
    chk("rs_load_ctrl",  160'(ctrl_o), 160'(C_R));
    chk("rs_load_data",  160'(data_o), 160'(d_add8));

    drive(0, '0, '0, 0);
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
